// File: rtl/ram_burst_reader_pkg.sv
// Shared FSM encoding and output-buffer sizing for the BRAM port-B burst reader.
package ram_burst_reader_pkg;

    typedef enum logic [1:0] {
        RBR_IDLE  = 2'd0,
        RBR_READ  = 2'd1,
        RBR_DRAIN = 2'd2,
        RBR_DONE  = 2'd3
    } rbr_state_e;

    localparam int unsigned RBR_FIFO_DEPTH = 2;
    localparam int unsigned RBR_CNT_W      = $clog2(RBR_FIFO_DEPTH + 1);

endpackage

// File: rtl/rbr_fifo2.sv
// Two-entry registered FIFO; the head entry is a register so the output stays stable
// until it is popped.
module rbr_fifo2
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_din,
    input  logic                 i_pop,
    output logic [RBR_CNT_W-1:0] o_count,
    output logic                 o_valid,
    output logic [WIDTH-1:0]     o_head
);

    logic [WIDTH-1:0]     r_head;
    logic [WIDTH-1:0]     r_tail;
    logic [RBR_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_din;
                    else                 r_tail <= i_din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_head <= i_din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != 2'd0);
    assign o_head  = r_head;

endmodule

// File: rtl/ram_burst_reader.sv
// Burst reader for BRAM port B: streams len words from base_addr onto a valid/ready port.
// Optional m_last output and per-entry last tag under `RAM_BURST_READER_LAST_EN.
module ram_burst_reader
    import ram_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   len,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_rd,
    input  logic [DATA_WIDTH-1:0]    ram_q,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
`ifdef RAM_BURST_READER_LAST_EN
    output logic                     m_last,
`endif
    input  logic                     m_ready
);

`ifdef RAM_BURST_READER_LAST_EN
    localparam int unsigned FIFO_W = DATA_WIDTH + 1;
`else
    localparam int unsigned FIFO_W = DATA_WIDTH;
`endif
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDRESS_WIDTH:0]   REM_ONE  = 1;
    localparam logic [ADDRESS_WIDTH:0]   REM_ZERO = 0;

    rbr_state_e               r_state;
    rbr_state_e               w_next_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH:0]   r_remaining;
    logic                     r_inflight;
    logic [RBR_CNT_W-1:0]     w_fifo_count;
    logic                     w_fifo_valid;
    logic [FIFO_W-1:0]        w_fifo_head;
    logic [FIFO_W-1:0]        w_fifo_din;
    logic                     w_pop;
    logic [2:0]               w_occupancy;
    logic                     w_issue;
    logic                     w_last_issue;

    assign w_pop        = w_fifo_valid & m_ready;
    assign w_occupancy  = 3'(w_fifo_count) + 3'(r_inflight);
    // Credit rule: buffered + in-RAM words after this cycle's pop must leave room.
    assign w_issue      = (r_state == RBR_READ) && (r_remaining != REM_ZERO)
                          && (w_occupancy < (3'd2 + 3'(w_pop)));
    assign w_last_issue = w_issue && (r_remaining == REM_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RBR_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RBR_IDLE:  if (start) w_next_state = (len == REM_ZERO) ? RBR_DONE : RBR_READ;
            RBR_READ:  if (w_last_issue) w_next_state = RBR_DRAIN;
            RBR_DRAIN: if (!r_inflight && !w_fifo_valid) w_next_state = RBR_DONE;
            RBR_DONE:  w_next_state = RBR_IDLE;
            default:   w_next_state = RBR_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == RBR_READ) || (r_state == RBR_DRAIN);
        done     = (r_state == RBR_DONE);
        ram_rd   = w_issue;
        ram_addr = r_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (r_state == RBR_IDLE && start) begin
                r_addr      <= base_addr;
                r_remaining <= len;
            end else if (w_issue) begin
                r_addr      <= r_addr + ADDR_ONE;
                r_remaining <= r_remaining - REM_ONE;
            end
        end
    end

`ifdef RAM_BURST_READER_LAST_EN
    logic r_inflight_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_inflight_last <= 1'b0;
        else        r_inflight_last <= w_last_issue;
    end

    assign w_fifo_din = {r_inflight_last, ram_q};
    assign m_last     = w_fifo_valid & w_fifo_head[DATA_WIDTH];
`else
    assign w_fifo_din = ram_q;
`endif

    rbr_fifo2 #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_count (w_fifo_count),
        .o_valid (w_fifo_valid),
        .o_head  (w_fifo_head)
    );

    assign m_valid = w_fifo_valid;
    assign m_data  = w_fifo_head[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader with a behavioural BRAM model and random back-pressure.
module tb_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base_addr = '0;
    logic [8:0] len = '0;
    logic       busy, done, ram_rd, m_valid;
    logic [7:0] ram_addr, m_data;
    logic [7:0] ram_q = '0;
    logic       m_ready = 1'b1;
`ifdef RAM_BURST_READER_LAST_EN
    logic       m_last;
`endif

    ram_burst_reader #(
        .DATA_WIDTH    (8),
        .ADDRESS_WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_rd    (ram_rd),
        .ram_q     (ram_q),
        .m_data    (m_data),
        .m_valid   (m_valid),
`ifdef RAM_BURST_READER_LAST_EN
        .m_last    (m_last),
`endif
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_addr_q [$];
    logic [7:0] exp_data_q [$];
    bit         exp_last_q [$];
    int issued = 0, popped = 0, rd_seen = 0, beat_seen = 0;
    bit         hold_pending = 1'b0;
    logic [7:0] held = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every issued address and every accepted beat against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            issued = 0;
            popped = 0;
            hold_pending = 1'b0;
            exp_addr_q.delete();
            exp_data_q.delete();
            exp_last_q.delete();
        end else begin
            if (ram_rd) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rd addr=%0h required=none", ram_addr);
                end else begin
                    chk("ram_addr", ram_addr, exp_addr_q.pop_front());
                end
                chk("credit_le2", (issued - popped + 1 - int'(m_valid && m_ready)) <= 2, 1);
                rd_seen++;
            end
            if (hold_pending) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat data=%0h required=none", m_data);
                end else begin
                    chk("m_data", m_data, exp_data_q.pop_front());
`ifdef RAM_BURST_READER_LAST_EN
                    chk("m_last", m_last, exp_last_q.pop_front());
`else
                    void'(exp_last_q.pop_front());
`endif
                end
                beat_seen++;
            end
            hold_pending = m_valid && !m_ready;
            held = m_data;
            issued += int'(ram_rd);
            popped += int'(m_valid && m_ready);
        end
    end

    // mode: 0 ready high, 1 pattern 1,0,0 repeating, 2 random
    task automatic burst(input logic [7:0] b, input logic [8:0] n, input int mode, input bit timed);
        int first_valid = -1;
        int done_cyc = -1;
        int rd0 = rd_seen;
        int beat0 = beat_seen;
        int budget = 4 * int'(n) + 30;
        for (int i = 0; i < int'(n); i++) begin
            logic [7:0] a;
            a = b + 8'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
            exp_last_q.push_back(i == int'(n) - 1);
        end
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = n;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'($urandom); len = 9'($urandom);
        for (int c = 1; c <= budget && done_cyc < 0; c++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((c - 1) % 3 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (m_valid && first_valid < 0) first_valid = c;
            if (timed && c == 1) begin
                chk("busy_cycle1", busy, n != 0);
                chk("rd_cycle1", ram_rd, n != 0);
            end
            if (done) begin
                done_cyc = c;
                chk("busy_at_done", busy, 0);
            end
            @(posedge clk); #1;
        end
        chk("done_seen", done_cyc >= 0, 1);
        if (timed) begin
            chk("first_valid_cycle", first_valid, (n == 0) ? -1 : 3);
            chk("done_cycle", done_cyc, (n == 0) ? 1 : int'(n) + 4);
        end
        chk("rd_count", rd_seen - rd0, n);
        chk("beat_count", beat_seen - beat0, n);
        chk("sb_empty", exp_data_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ram_rd", ram_rd, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
`ifdef RAM_BURST_READER_LAST_EN
        chk("rst_m_last", m_last, 0);
`endif
        #5 rst_n = 1'b1;

        burst(8'h10, 9'd4, 0, 1'b1);
        burst(8'h10, 9'd4, 1, 1'b0);
        burst(8'hFE, 9'd4, 0, 1'b1);
        burst(8'h00, 9'd0, 0, 1'b1);
        burst(8'h30, 9'd3, 0, 1'b1);
        burst(8'h77, 9'd1, 0, 1'b1);

        // Reset while two words sit in the buffer during DRAIN.
        for (int i = 0; i < 2; i++) begin
            exp_addr_q.push_back(8'h20 + 8'(i));
            exp_data_q.push_back(mem[8'h20 + 8'(i)]);
            exp_last_q.push_back(i == 1);
        end
        @(posedge clk); #1;
        m_ready = 1'b0; start = 1'b1; base_addr = 8'h20; len = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rd", ram_rd, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        m_ready = 1'b1;
        burst(8'h40, 9'd5, 0, 1'b1);

        for (int k = 0; k < 30; k++) begin
            if (k % 10 == 0) for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            burst(8'($urandom), 9'($urandom_range(0, 12)), (k % 3 == 0) ? 1 : 2, 1'b0);
        end
        burst(8'($urandom), 9'd260, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
